// File: rtl/mem_axi_bridge_pkg.sv
// Shared definitions for the MMU-to-AXI4-Lite bridge: request modes,
// AXI response codes, bridge state encoding and small decode helpers.
package mem_axi_bridge_pkg;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRITE_B,
    ST_READ_AR,
    ST_READ_R,
    ST_RESP
  } axi_bridge_state_t;

  // Only word-aligned accesses are legal on a 32-bit bus.
  function automatic logic isMisaligned(input logic [1:0] addrLsb);
    return addrLsb != 2'b00;
  endfunction

  // SLVERR and DECERR both report as an error; OKAY and EXOKAY do not.
  function automatic logic isErrorResp(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/mem_axi_bridge.sv
// Bridge between the MMU's one-beat physical request interface and a single
// AXI4-Lite master port. One transaction outstanding at a time; every request
// ends in exactly one response_enable pulse.
module mem_axi_bridge
  import mem_axi_bridge_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [2:0]  AXI_PROT   = 3'b000
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  request_enable,
  input  logic                  req_mode,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  response_enable,
  output logic [31:0]           resp_data,
  output logic                  resp_error,
  output logic                  busy,

  output logic                  m_axi_awvalid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  input  logic                  m_axi_awready,

  output logic                  m_axi_wvalid,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  input  logic                  m_axi_wready,

  input  logic                  m_axi_bvalid,
  input  logic [1:0]            m_axi_bresp,
  output logic                  m_axi_bready,

  output logic                  m_axi_arvalid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  input  logic                  m_axi_arready,

  input  logic                  m_axi_rvalid,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  output logic                  m_axi_rready
);

  axi_bridge_state_t     r_state;
  axi_bridge_state_t     w_nextState;

  logic                  r_awvalid, w_nextAwvalid;
  logic                  r_wvalid, w_nextWvalid;
  logic                  r_bready, w_nextBready;
  logic                  r_arvalid, w_nextArvalid;
  logic                  r_rready, w_nextRready;
  logic                  r_respEnable, w_nextRespEnable;
  logic                  r_respError, w_nextRespError;
  logic                  r_busy, w_nextBusy;
  logic [31:0]           r_respData, w_nextRespData;
  logic [ADDR_WIDTH-1:0] r_addr, w_nextAddr;
  logic [31:0]           r_wdata, w_nextWdata;
  logic [3:0]            r_wstrb, w_nextWstrb;

  // A channel counts as done once its valid has dropped or is being accepted now,
  // so AW and W can finish in either order or together.
  logic w_awDone;
  logic w_wDone;
  assign w_awDone = !r_awvalid || m_axi_awready;
  assign w_wDone  = !r_wvalid  || m_axi_wready;

  // State and all registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_respEnable <= 1'b0;
      r_respError  <= 1'b0;
      r_busy       <= 1'b0;
      r_respData   <= 32'd0;
      r_addr       <= '0;
      r_wdata      <= 32'd0;
      r_wstrb      <= 4'd0;
    end else begin
      r_state      <= w_nextState;
      r_awvalid    <= w_nextAwvalid;
      r_wvalid     <= w_nextWvalid;
      r_bready     <= w_nextBready;
      r_arvalid    <= w_nextArvalid;
      r_rready     <= w_nextRready;
      r_respEnable <= w_nextRespEnable;
      r_respError  <= w_nextRespError;
      r_busy       <= w_nextBusy;
      r_respData   <= w_nextRespData;
      r_addr       <= w_nextAddr;
      r_wdata      <= w_nextWdata;
      r_wstrb      <= w_nextWstrb;
    end
  end

  // Next-state and next-output decode; every register holds unless a handshake moves it.
  always_comb begin
    w_nextState      = r_state;
    w_nextAwvalid    = r_awvalid;
    w_nextWvalid     = r_wvalid;
    w_nextBready     = r_bready;
    w_nextArvalid    = r_arvalid;
    w_nextRready     = r_rready;
    w_nextRespEnable = r_respEnable;
    w_nextRespError  = r_respError;
    w_nextBusy       = r_busy;
    w_nextRespData   = r_respData;
    w_nextAddr       = r_addr;
    w_nextWdata      = r_wdata;
    w_nextWstrb      = r_wstrb;

    case (r_state)
      ST_IDLE: begin
        if (request_enable) begin
          w_nextAddr  = req_addr;
          w_nextWdata = req_wdata;
          w_nextWstrb = req_wstrb;
          w_nextBusy  = 1'b1;
          if (isMisaligned(req_addr[1:0])) begin
            // No bus traffic; RESP is entered with the pulse still low so the
            // completion lands one cycle later, in the second RESP cycle.
            w_nextState      = ST_RESP;
            w_nextRespError  = 1'b1;
            w_nextRespData   = 32'd0;
            w_nextRespEnable = 1'b0;
          end else if (req_mode == MEMREQ_WRITE) begin
            w_nextState   = ST_WRITE;
            w_nextAwvalid = 1'b1;
            w_nextWvalid  = 1'b1;
          end else begin
            w_nextState   = ST_READ_AR;
            w_nextArvalid = 1'b1;
          end
        end
      end

      ST_WRITE: begin
        if (r_awvalid && m_axi_awready) begin
          w_nextAwvalid = 1'b0;
        end
        if (r_wvalid && m_axi_wready) begin
          w_nextWvalid = 1'b0;
        end
        if (w_awDone && w_wDone) begin
          w_nextState  = ST_WRITE_B;
          w_nextBready = 1'b1;
        end
      end

      ST_WRITE_B: begin
        if (r_bready && m_axi_bvalid) begin
          w_nextBready     = 1'b0;
          w_nextRespError  = isErrorResp(m_axi_bresp);
          w_nextRespData   = 32'd0;
          w_nextRespEnable = 1'b1;
          w_nextState      = ST_RESP;
        end
      end

      ST_READ_AR: begin
        if (r_arvalid && m_axi_arready) begin
          w_nextArvalid = 1'b0;
          w_nextRready  = 1'b1;
          w_nextState   = ST_READ_R;
        end
      end

      ST_READ_R: begin
        if (r_rready && m_axi_rvalid) begin
          w_nextRready     = 1'b0;
          w_nextRespError  = isErrorResp(m_axi_rresp);
          w_nextRespData   = isErrorResp(m_axi_rresp) ? 32'd0 : m_axi_rdata;
          w_nextRespEnable = 1'b1;
          w_nextState      = ST_RESP;
        end
      end

      ST_RESP: begin
        if (r_respEnable) begin
          w_nextRespEnable = 1'b0;
          w_nextBusy       = 1'b0;
          w_nextState      = ST_IDLE;
        end else begin
          w_nextRespEnable = 1'b1;
        end
      end

      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  assign response_enable = r_respEnable;
  assign resp_data       = r_respData;
  assign resp_error      = r_respError;
  assign busy            = r_busy;

  assign m_axi_awvalid = r_awvalid;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awprot  = AXI_PROT;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_bready  = r_bready;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arprot  = AXI_PROT;
  assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Self-checking bench for mem_axi_bridge: a behavioural AXI4-Lite slave with
// per-request ready delays, a response scoreboard, a vector table and a few
// hand-written multi-cycle sequences (reset mid-write, back-to-back, ignored requests).
module tb_mem_axi_bridge;
  import mem_axi_bridge_pkg::*;

  logic        clk;
  logic        rst;
  logic        request_enable;
  logic        req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        response_enable;
  logic [31:0] resp_data;
  logic        resp_error;
  logic        busy;
  logic        m_axi_awvalid;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awready;
  logic        m_axi_wvalid;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wready;
  logic        m_axi_bvalid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bready;
  logic        m_axi_arvalid;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arready;
  logic        m_axi_rvalid;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rready;

  mem_axi_bridge dut (
    .clk(clk), .rst(rst),
    .request_enable(request_enable), .req_mode(req_mode), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .response_enable(response_enable), .resp_data(resp_data),
    .resp_error(resp_error), .busy(busy),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awprot(m_axi_awprot), .m_axi_awready(m_axi_awready),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wready(m_axi_wready),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rready(m_axi_rready)
  );

  typedef struct {
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [1:0]  bresp;
    int          awDelay;
    int          wDelay;
    int          arDelay;
    logic [31:0] expData;
    logic        expError;
    int          expLatency;
  } vector_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          latency;
    int          reqCycle;
  } expResp_t;

  expResp_t sbQueue[$];
  vector_t  vectors[7];

  int checks = 0;
  int errors = 0;

  // Slave configuration, written by the main sequence before each request.
  int          cfgAwDelay = 0;
  int          cfgWDelay  = 0;
  int          cfgArDelay = 0;
  logic [31:0] cfgRdata   = 32'd0;
  logic [1:0]  cfgRresp   = 2'b00;
  logic [1:0]  cfgBresp   = 2'b00;

  // Bus observations, written only by the monitor process.
  int          cycle = 0;
  int          awCount = 0, wCount = 0, bCount = 0, arCount = 0, rCount = 0;
  int          arvalidCycles = 0;
  int          awWait = 0, wWait = 0, arWait = 0;
  int          awHsCycle = 0, wHsCycle = 0;
  logic        awSeen = 1'b0, wSeen = 1'b0, bPending = 1'b0, rPending = 1'b0;
  logic [31:0] seenAwAddr = 32'd0, seenWData = 32'd0, seenArAddr = 32'd0;
  logic [3:0]  seenWStrb = 4'd0;
  logic [2:0]  seenAwProt = 3'd0, seenArProt = 3'd0;

  // Snapshots taken by the main sequence when a request is driven.
  int awBase, wBase, bBase, arBase, arvBase;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so a wedged DUT still ends the run with a visible FAIL.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got stuck expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: sees pre-edge values at each rising edge and records every handshake.
  initial begin
    forever begin
      @(posedge clk);
      cycle++;
      if (rst) begin
        awWait = 0; wWait = 0; arWait = 0;
        awSeen = 1'b0; wSeen = 1'b0; bPending = 1'b0; rPending = 1'b0;
      end else begin
        if (m_axi_bvalid && m_axi_bready) begin
          bCount++;
          bPending = 1'b0;
        end
        if (m_axi_rvalid && m_axi_rready) begin
          rCount++;
          rPending = 1'b0;
        end
        if (m_axi_awvalid && m_axi_awready) begin
          awCount++; awSeen = 1'b1; awWait = 0; awHsCycle = cycle;
          seenAwAddr = m_axi_awaddr; seenAwProt = m_axi_awprot;
        end else if (m_axi_awvalid) begin
          awWait++;
        end
        if (m_axi_wvalid && m_axi_wready) begin
          wCount++; wSeen = 1'b1; wWait = 0; wHsCycle = cycle;
          seenWData = m_axi_wdata; seenWStrb = m_axi_wstrb;
        end else if (m_axi_wvalid) begin
          wWait++;
        end
        if (awSeen && wSeen) begin
          bPending = 1'b1; awSeen = 1'b0; wSeen = 1'b0;
        end
        if (m_axi_arvalid) arvalidCycles++;
        if (m_axi_arvalid && m_axi_arready) begin
          arCount++; rPending = 1'b1; arWait = 0;
          seenArAddr = m_axi_araddr; seenArProt = m_axi_arprot;
        end else if (m_axi_arvalid) begin
          arWait++;
        end
      end
    end
  end

  // Slave driver: updates its outputs on the falling edge, away from the DUT's sampling edge.
  initial begin
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    m_axi_rvalid = 1'b0; m_axi_rdata = 32'd0; m_axi_rresp = 2'b00;
    forever begin
      @(negedge clk);
      m_axi_awready = m_axi_awvalid && (awWait >= cfgAwDelay);
      m_axi_wready  = m_axi_wvalid  && (wWait  >= cfgWDelay);
      m_axi_arready = m_axi_arvalid && (arWait >= cfgArDelay);
      m_axi_bvalid  = bPending;
      m_axi_bresp   = cfgBresp;
      m_axi_rvalid  = rPending;
      m_axi_rdata   = cfgRdata;
      m_axi_rresp   = cfgRresp;
    end
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Idle for n cycles; no completion pulse may appear while nothing is expected.
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkVal("noSpuriousResp", 32'(response_enable), 32'd0);
    end
  endtask

  // Drives one accepted request for one cycle and records its expected response.
  // Called on a falling edge; returns on the next falling edge.
  task automatic applyStimulus(input vector_t v);
    expResp_t e;
    cfgAwDelay = v.awDelay; cfgWDelay = v.wDelay; cfgArDelay = v.arDelay;
    cfgRdata = v.rdata; cfgRresp = v.rresp; cfgBresp = v.bresp;
    awBase = awCount; wBase = wCount; bBase = bCount; arBase = arCount;
    arvBase = arvalidCycles;
    e.data = v.expData; e.err = v.expError; e.latency = v.expLatency; e.reqCycle = cycle;
    sbQueue.push_back(e);
    request_enable = 1'b1;
    req_mode = v.mode; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb;
    @(negedge clk);
    request_enable = 1'b0;
  endtask

  // A request strobe the DUT must ignore: no scoreboard entry is pushed.
  task automatic pulseIgnored(input logic mode, input logic [31:0] addr);
    request_enable = 1'b1;
    req_mode = mode; req_addr = addr; req_wdata = 32'hFEED_FACE; req_wstrb = 4'hF;
    @(negedge clk);
    request_enable = 1'b0;
  endtask

  // Waits (bounded) for the completion pulse and pops/compares the scoreboard.
  // Returns on the falling edge of the response cycle.
  task automatic waitResponse(input string name);
    expResp_t e;
    logic got;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (response_enable) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("[TB] FAIL %s_timeout: got no response_enable expected one within 100 cycles", name);
      if (sbQueue.size() > 0) void'(sbQueue.pop_front());
    end else if (sbQueue.size() == 0) begin
      checks++; errors++;
      $display("[TB] FAIL %s_unexpected: got response_enable expected none outstanding", name);
    end else begin
      e = sbQueue.pop_front();
      checkVal({name, "_data"}, resp_data, e.data);
      checkVal({name, "_error"}, 32'(resp_error), 32'(e.err));
      checkVal({name, "_latency"}, 32'(cycle - e.reqCycle), 32'(e.latency));
      checkVal({name, "_busyInResp"}, 32'(busy), 32'd1);
    end
  endtask

  // Compares the bus traffic a vector produced against what its request implies.
  task automatic checkOutput(input vector_t v, input string name);
    logic aligned, expAr, expAw;
    aligned = (v.addr[1:0] == 2'b00);
    expAr   = aligned && (v.mode == MEMREQ_READ);
    expAw   = aligned && (v.mode == MEMREQ_WRITE);
    checkVal({name, "_arCount"}, 32'(arCount - arBase), 32'(expAr));
    checkVal({name, "_awCount"}, 32'(awCount - awBase), 32'(expAw));
    checkVal({name, "_wCount"},  32'(wCount - wBase),   32'(expAw));
    checkVal({name, "_bCount"},  32'(bCount - bBase),   32'(expAw));
    checkVal({name, "_arvalidCycles"}, 32'(arvalidCycles - arvBase),
             expAr ? 32'(1 + v.arDelay) : 32'd0);
    if (expAr) begin
      checkVal({name, "_araddr"}, seenArAddr, v.addr);
      checkVal({name, "_arprot"}, 32'(seenArProt), 32'd0);
    end
    if (expAw) begin
      checkVal({name, "_awaddr"}, seenAwAddr, v.addr);
      checkVal({name, "_awprot"}, 32'(seenAwProt), 32'd0);
      checkVal({name, "_wdata"},  seenWData, v.wdata);
      checkVal({name, "_wstrb"},  32'(seenWStrb), 32'(v.wstrb));
      if (v.awDelay != v.wDelay)
        checkVal({name, "_wBeforeAw"}, 32'(wHsCycle < awHsCycle), 32'(v.wDelay < v.awDelay));
    end
    @(negedge clk);
    checkVal({name, "_busyCleared"}, 32'(busy), 32'd0);
    checkVal({name, "_respDataHold"}, resp_data, v.expData);
    checkVal({name, "_respErrorHold"}, 32'(resp_error), 32'(v.expError));
  endtask

  initial begin
    vector_t v;
    int arSnap, awSnap;

    //            mode          addr          wdata         wstrb    rdata         rresp  bresp  aw wd ar expData       err  lat
    vectors[0] = '{MEMREQ_READ,  32'h8000_0100, 32'h0,        4'b0000, 32'hDEAD_BEEF, 2'b00, 2'b00, 0, 0, 0, 32'hDEAD_BEEF, 1'b0, 3};
    vectors[1] = '{MEMREQ_WRITE, 32'h0000_2004, 32'h1234_5678, 4'b0011, 32'h0,        2'b00, 2'b00, 3, 0, 0, 32'h0,        1'b0, 6};
    vectors[2] = '{MEMREQ_READ,  32'h0000_3000, 32'h0,        4'b0000, 32'hFFFF_FFFF, 2'b10, 2'b00, 0, 0, 0, 32'h0,        1'b1, 3};
    vectors[3] = '{MEMREQ_READ,  32'h0000_1002, 32'h0,        4'b0000, 32'hCAFE_0000, 2'b00, 2'b00, 0, 0, 0, 32'h0,        1'b1, 2};
    vectors[4] = '{MEMREQ_WRITE, 32'h4000_0010, 32'hA5A5_5A5A, 4'b0000, 32'h0,        2'b00, 2'b11, 0, 2, 0, 32'h0,        1'b1, 5};
    vectors[5] = '{MEMREQ_READ,  32'h0000_0040, 32'h0,        4'b0000, 32'h0BAD_F00D, 2'b01, 2'b00, 0, 0, 2, 32'h0BAD_F00D, 1'b0, 5};
    vectors[6] = '{MEMREQ_WRITE, 32'h0000_0003, 32'h1111_2222, 4'b1111, 32'h0,        2'b00, 2'b00, 0, 0, 0, 32'h0,        1'b1, 2};

    rst = 1'b1;
    request_enable = 1'b0; req_mode = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_wstrb = 4'd0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkVal("rst_awvalid", 32'(m_axi_awvalid), 32'd0);
    checkVal("rst_wvalid",  32'(m_axi_wvalid),  32'd0);
    checkVal("rst_arvalid", 32'(m_axi_arvalid), 32'd0);
    checkVal("rst_bready",  32'(m_axi_bready),  32'd0);
    checkVal("rst_rready",  32'(m_axi_rready),  32'd0);
    checkVal("rst_respEn",  32'(response_enable), 32'd0);
    checkVal("rst_respErr", 32'(resp_error), 32'd0);
    checkVal("rst_busy",    32'(busy), 32'd0);
    checkVal("rst_respData", resp_data, 32'd0);
    checkVal("rst_awaddr",  m_axi_awaddr, 32'd0);

    rst = 1'b0;
    idleCycles(2);

    $display("[TB] vector table");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vectors[i]);
      waitResponse($sformatf("vec%0d", i));
      checkOutput(vectors[i], $sformatf("vec%0d", i));
      idleCycles(1);
    end

    $display("[TB] reset while awvalid is stalled");
    v = '{MEMREQ_WRITE, 32'h0000_6000, 32'h5555_AAAA, 4'b1111, 32'h0, 2'b00, 2'b00,
          1000, 1000, 0, 32'h0, 1'b0, 3};
    applyStimulus(v);
    idleCycles(2);
    checkVal("midRst_awvalidBefore", 32'(m_axi_awvalid), 32'd1);
    rst = 1'b1;
    #1;
    checkVal("midRst_awvalid", 32'(m_axi_awvalid), 32'd0);
    checkVal("midRst_wvalid",  32'(m_axi_wvalid),  32'd0);
    checkVal("midRst_busy",    32'(busy), 32'd0);
    sbQueue.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idleCycles(1);
    v = '{MEMREQ_READ, 32'h0000_0800, 32'h0, 4'b0000, 32'h7777_1234, 2'b00, 2'b00,
          0, 0, 0, 32'h7777_1234, 1'b0, 3};
    applyStimulus(v);
    waitResponse("afterRst");
    checkOutput(v, "afterRst");

    $display("[TB] back-to-back and request during RESP");
    arSnap = arCount;
    v = '{MEMREQ_READ, 32'h0000_0A00, 32'h0, 4'b0000, 32'h0000_00A1, 2'b00, 2'b00,
          0, 0, 0, 32'h0000_00A1, 1'b0, 3};
    applyStimulus(v);
    waitResponse("b2bFirst");
    pulseIgnored(MEMREQ_READ, 32'h0000_0F00);
    v = '{MEMREQ_READ, 32'h0000_0B00, 32'h0, 4'b0000, 32'h0000_00B2, 2'b00, 2'b00,
          0, 0, 0, 32'h0000_00B2, 1'b0, 3};
    applyStimulus(v);
    waitResponse("b2bSecond");
    checkVal("b2b_arTotal", 32'(arCount - arSnap), 32'd2);
    checkVal("b2b_araddr", seenArAddr, 32'h0000_0B00);
    idleCycles(3);

    $display("[TB] request while busy");
    arSnap = arCount;
    awSnap = awCount;
    v = '{MEMREQ_READ, 32'h0000_0C00, 32'h0, 4'b0000, 32'h0000_00C3, 2'b00, 2'b00,
          0, 0, 2, 32'h0000_00C3, 1'b0, 5};
    applyStimulus(v);
    checkVal("busyIgn_busy", 32'(busy), 32'd1);
    pulseIgnored(MEMREQ_WRITE, 32'h0000_5000);
    waitResponse("busyIgn");
    idleCycles(3);
    checkVal("busyIgn_arTotal", 32'(arCount - arSnap), 32'd1);
    checkVal("busyIgn_awTotal", 32'(awCount - awSnap), 32'd0);
    checkVal("busyIgn_araddr", seenArAddr, 32'h0000_0C00);
    checkVal("sb_empty", 32'(sbQueue.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
